// File: rtl/bram_req_master.sv
// -----------------------------------------------------------------------------
// bram_req_master
//
// Initiator-side front end for a single-port synchronous block RAM.
// Requests arrive on a ready/valid interface and are forwarded to the RAM
// command port combinationally, so the accept cycle is the command cycle.
// Read data, valid one cycle after the read command, is captured into a
// small response FIFO and returned in order on a ready/valid response port.
// Request acceptance is credit-limited by FIFO occupancy plus the in-flight
// read, so response back-pressure can never overwrite a read datum.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   req_valid_i    request present
//   req_ready_o    request accepted when high with req_valid_i
//   req_we_i       1 = write, 0 = read
//   req_addr_i     word address
//   req_data_i     write data (ignored for reads)
//   rsp_valid_o    read response present
//   rsp_ready_i    response consumed when high with rsp_valid_o
//   rsp_data_o     read data
//   bram_cmd_en_o  RAM command enable
//   bram_wr_en_o   RAM write enable
//   bram_addr_o    RAM address
//   bram_data_o    RAM write data
//   bram_data_i    RAM read data, valid the cycle after a read command
// -----------------------------------------------------------------------------
module bram_req_master #(
    parameter int DATA_WIDTH = 32,
    parameter int BRAM_DEPTH = 128,
    parameter int RSP_DEPTH  = 4,
    localparam int ADDR_WIDTH = $clog2(BRAM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  bram_cmd_en_o,
    output logic                  bram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic [DATA_WIDTH-1:0] bram_data_o,
    input  logic [DATA_WIDTH-1:0] bram_data_i
);

    localparam int OCC_WIDTH = $clog2(RSP_DEPTH + 1);
    localparam int PTR_WIDTH = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic                  acc;
    logic                  push;
    logic                  pop;
    logic                  rd_pend_reg;
    logic [OCC_WIDTH-1:0]  occ_reg;
    logic [OCC_WIDTH-1:0]  occ_next;
    logic [PTR_WIDTH-1:0]  wr_ptr_reg;
    logic [PTR_WIDTH-1:0]  rd_ptr_reg;
    logic [OCC_WIDTH:0]    credit_used;
    logic [DATA_WIDTH-1:0] entry_vec [RSP_DEPTH];

    // Pointers wrap modulo RSP_DEPTH, which need not be a power of two.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit: a read in flight already owns a FIFO slot. Only registered
    // state (and reset) feeds ready, so there is no path from rsp_ready_i.
    assign credit_used = {1'b0, occ_reg} + {{OCC_WIDTH{1'b0}}, rd_pend_reg};
    assign req_ready_o = ~rst_i & (credit_used < (OCC_WIDTH + 1)'(RSP_DEPTH));

    assign acc = req_valid_i & req_ready_o;

    assign bram_cmd_en_o = acc;
    assign bram_wr_en_o  = acc & req_we_i;
    assign bram_addr_o   = req_addr_i;
    assign bram_data_o   = req_data_i;

    // Only the cycle after a read command samples the RAM output.
    assign push = rd_pend_reg;
    assign pop  = rsp_valid_o & rsp_ready_i;

    assign rsp_valid_o = (occ_reg != '0);
    assign rsp_data_o  = entry_vec[rd_ptr_reg];

    always_comb begin
        occ_next = occ_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + OCC_WIDTH'(1);
            2'b01:   occ_next = occ_reg - OCC_WIDTH'(1);
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_pend_reg <= 1'b0;
            occ_reg     <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
        end else begin
            rd_pend_reg <= acc & ~req_we_i;
            occ_reg     <= occ_next;
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
        end
    end

    // FIFO storage: one resettable register per entry so the head reads 0
    // after reset.
    genvar gi;
    generate
        for (gi = 0; gi < RSP_DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] entry_reg;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == PTR_WIDTH'(gi))) begin
                    entry_reg <= bram_data_i;
                end
            end

            assign entry_vec[gi] = entry_reg;
        end
    endgenerate

    // The credit rule makes overflow impossible; catch any regression.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && !pop && (occ_reg == OCC_WIDTH'(RSP_DEPTH))));
        end
    end

endmodule

// File: doc/bram_req_master.md
# bram_req_master

Initiator-side front end for the single-port synchronous block RAM used throughout the design. It accepts read/write requests on a ready/valid interface and drives the RAM's command port (`cmd_en`, `wr_en`, `addr`, `data`) directly. It also captures read data, which arrives one cycle after the command, and returns it in order on a ready/valid response interface. A credit-limited response FIFO makes downstream back-pressure lossless, so no read datum is ever overwritten inside the RAM's output register.

## Interface
- `DATA_WIDTH`, 32, RAM word width.
- `BRAM_DEPTH`, 128, number of RAM words; derived localparam `ADDR_WIDTH = $clog2(BRAM_DEPTH)`.
- `RSP_DEPTH`, 4, response FIFO entries; legal range ≥2. Values ≥3 give one read per cycle sustained.

Ports. Clocking is fixed: one clock; reset is asynchronous and active-high.
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  request accepted when high together with `req_valid_i`.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  ADDR_WIDTH  word address.
- `req_data_i`  in  DATA_WIDTH  write data; ignored for reads.
- `rsp_valid_o`  out  1  read response present.
- `rsp_ready_i`  in  1  response consumed when high together with `rsp_valid_o`.
- `rsp_data_o`  out  DATA_WIDTH  read data.
- `bram_cmd_en_o`  out  1  RAM command enable.
- `bram_wr_en_o`  out  1  RAM write enable.
- `bram_addr_o`  out  ADDR_WIDTH  RAM address.
- `bram_data_o`  out  DATA_WIDTH  RAM write data.
- `bram_data_i`  in  DATA_WIDTH  RAM read data; valid the cycle after a read command.

## Operation
- Accept is defined as `acc = req_valid_i & req_ready_o`.
- The RAM command is combinational from the request, so the accept cycle is the command cycle:
  - `bram_cmd_en_o = acc`
  - `bram_wr_en_o = acc & req_we_i`
  - `bram_addr_o = req_addr_i`
  - `bram_data_o = req_data_i`
- Write requests produce no response.
- State:
  - `rd_pend` (1 bit): set at the end of a read-accept cycle, otherwise cleared.
  - FIFO occupancy `occ` (width `$clog2(RSP_DEPTH+1)`), plus read/write pointers that wrap modulo `RSP_DEPTH`.
- Push: in any cycle with `rd_pend=1`, `bram_data_i` is written to the FIFO tail. No other cycle samples `bram_data_i`, so undefined or Z RAM output after writes is never captured.
- Pop: happens when `rsp_valid_o & rsp_ready_i`.
  - `rsp_valid_o = (occ != 0)`.
  - `rsp_data_o` = FIFO head entry.
- Push and pop in the same cycle leave `occ` unchanged and advance both pointers.
- Credit rule: `req_ready_o = ~rst_i & ((occ + rd_pend) < RSP_DEPTH)`.
  - Depends only on registered state; there is no combinational path from `rsp_ready_i` or `req_valid_i`.
  - Applies to writes as well as reads.
- Ordering: responses are returned strictly in read-accept order. A write accepted between two reads is visible to the later read but not the earlier one.
- No overflow by construction. A push into a full FIFO is a design error; flag it with a simulation assertion.

## Timing
- Reset values (async, while `rst_i=1`):
  - `occ=0`, pointers 0, `rd_pend=0`, FIFO contents and `rsp_data_o` 0.
  - `rsp_valid_o=0`, `req_ready_o=0`, `bram_cmd_en_o=0`, `bram_wr_en_o=0`.
- `req_ready_o=1` from the first cycle after `rst_i` deasserts.
- Read latency: accept in cycle N → RAM samples at edge N → `bram_data_i` valid in N+1 → pushed at edge N+1 → `rsp_valid_o=1` in N+2.
- Write latency: RAM updated at the edge ending the accept cycle; no output.
- Throughput:
  - `RSP_DEPTH≥3` with `rsp_ready_i=1`: one read accepted per cycle indefinitely.
  - `RSP_DEPTH=2`: two reads per three cycles.
- Full condition: `occ + rd_pend = RSP_DEPTH` forces `req_ready_o=0`. After a pop in cycle K, `req_ready_o` rises in K+1.
- Reset mid-operation:
  - A pending read is discarded; `rd_pend` clears and the following `bram_data_i` is ignored.
  - Queued responses are lost.
  - Any request presented during reset is not accepted.

## Test plan
- Reset: hold `rst_i=1` for 3 cycles with `req_valid_i=1` → all outputs 0 and no `bram_cmd_en_o` pulse; `req_ready_o=1` on the first cycle after release.
- Single write/read: write 0xDEADBEEF to addr 5 (accepted cycle N), then read addr 5 (accepted N+1) → `bram_cmd_en_o`/`bram_wr_en_o` = 1/1 then 1/0; `rsp_valid_o=1` with 0xDEADBEEF in N+3, exactly one response.
- Streaming: preload addr i with i×0x11 for i=0..7, `RSP_DEPTH=4`, issue 8 back-to-back reads with `rsp_ready_i=1` → `req_ready_o` never drops; responses 0x00,0x11,…,0x77 on 8 consecutive cycles starting 2 cycles after the first accept.
- Back-pressure: `rsp_ready_i=0`, `req_valid_i` held for reads of addr 0..9 → exactly 4 accepted, then `req_ready_o=0` with `occ=4`. Raise `rsp_ready_i` → responses 0x00,0x11,0x22,0x33 in order; `req_ready_o` returns 1 the cycle after the first pop; no data lost.
- Read/write hazard: addr 3 holds 0x1111. Read 3, write 3 ← 0x2222, read 3 on consecutive cycles → responses 0x1111 then 0x2222.
- Reset mid-read: accept a read of addr 2, assert `rst_i` in the following cycle for one cycle → no response ever appears; `occ=0` after reset; a fresh read of addr 2 returns the correct value with normal 2-cycle latency.
